pe_pipe: RTL and testbench
==========================

# pe_pipe

Parametrised successor to the single processing element's back-end datapath. It takes `N_CH` per-channel MAC results per cycle and reduces them through a registered adder tree. It optionally accumulates a partial sum fed back from a previous filter bank, saturates the result, and applies a selectable non-linearity and a 2x2 max-pool through an internal half-row line buffer. It sits between the convolver array and the output/partial-sum write-back path of the PE array.

## Interface
- `N_CH`, 16: number of channel inputs reduced per cycle (≥1).
- `W`, 16: signed data width of channel inputs, partial sum and output.
- `MAX_ROW`, 256: maximum row length in pixels; the line buffer holds `MAX_ROW/2` words.
- `RA`, 8: row-length / column counter width (`2^RA ≥ MAX_ROW`).
- `CLAMP_MAX`, 16'h0600: upper clamp for nl_type 3.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  qualifies `in_data` and `psum_in` this cycle.
- `in_data`  in  `W*N_CH`  packed signed channel products, channel 0 in LSBs.
- `psum_in`  in  `W`  signed feedback partial sum.
- `acc_en`  in  1  1: add `psum_in` to the tree sum.
- `final_bank`  in  1  0: emit saturated sum raw (NL/pool bypassed); 1: apply NL and pool.
- `nl_type`  in  3  0 pass, 1 ReLU, 2 leaky (neg: x>>>3), 3 clamp [0,CLAMP_MAX], others pass.
- `pool_en`  in  1  enable 2x2 max-pool (only when `final_bank`=1).
- `row_length`  in  `RA`  pixels per input row when pooling.
- `pool_clear`  in  1  pulse: restart pooling at column 0, even row.
- `out_valid`  out  1  qualifies `out_data`.
- `out_data`  out  `W`  signed result.
- `pipe_empty`  out  1  no valid sample in flight.
- `cfg_err`  out  1  sticky: `pool_en` with `row_length`<2; cleared by reset or `pool_clear`.

## Operation
- No backpressure. Every `in_valid` sample advances one stage per cycle. A valid bit travels with each stage.
- Tree: `T = clog2(N_CH)` registered levels (T=0 for N_CH=1). Sums are sign-extended to `W+T` bits with no intermediate overflow.
- Accumulate stage (registered): `s = tree + (acc_en ? sext(psum_in) : 0)`, then saturate to [-2^(W-1), 2^(W-1)-1]. `acc_en` and `psum_in` are sampled with `in_valid` and delayed alongside the data.
- NL stage (registered): applied per `nl_type` when `final_bank`=1, otherwise pass.
- Pool/output stage (registered). Pooling is active when `pool_en && final_bank`; otherwise each NL result is registered straight to `out_data`.
- Pool FSM states: EVEN_A, EVEN_B, ODD_A, ODD_B. The column counter `col` is 0..row_length-1.
  - EVEN_A: hold the pixel in `h`.
  - EVEN_B: write `max(h,x)` to `lb[col>>1]`.
  - ODD_A: hold the pixel in `h`.
  - ODD_B: emit `max(lb[col>>1], h, x)` with `out_valid`=1.
  - The A/B toggle is per pixel.
  - At `col`=row_length-1, `col` wraps to 0 and the even/odd row parity toggles. The next state is EVEN_A or ODD_A.
- Odd `row_length`: the last pixel of each row is dropped (A held, never paired). Row wrap still occurs.
- `row_length`<2 with pooling: no pool outputs, `cfg_err` sets, and samples are discarded.
- `pool_clear`: state goes to EVEN_A and `col` to 0. It has priority over a coincident pool-stage sample, and that sample is processed as column 0 of the new even row.
- Line buffer contents are not reset. The first read of any entry is always preceded by an even-row write.
- `final_bank`, `nl_type`, `pool_en` and `row_length` may change only while `pipe_empty`=1. Otherwise behaviour is undefined.

## Timing
- Latency from `in_valid` to the corresponding stage-output register is `T+3` cycles (N_CH=16: 7).
  - Non-pool: one `out_valid` per input, at cycle `T+3`.
  - Pool: one `out_valid` per 2x2 window, `T+3` cycles after that window's last pixel.
- Throughput is 1 sample per cycle, sustained.
- `out_valid` is a single-cycle pulse per result. `out_data` holds its last value when `out_valid`=0.
- Reset (rst=0 at a clock edge) sets the following:
  - `out_valid`=0, `out_data`=0, `cfg_err`=0, `pipe_empty`=1.
  - All stage valids 0, FSM EVEN_A, `col`=0.
  - In-flight samples are discarded. Reset mid-row is equivalent to `pool_clear` plus a pipeline flush.
- `pipe_empty`=1 when all stage valids are 0. It is registered off the stage valid bits.

## Test plan
- N_CH=4, W=16, non-pool, `final_bank`=0, `acc_en`=0. Input {1,2,3,4}, then {-5,0,0,0}. Expect out 10 at cycle 5 and -5 at cycle 6, back-to-back.
- Saturation and accumulate: all channels 16'h7000 plus `psum_in`=16'h7000 with `acc_en`=1 gives 16'h7FFF. All channels 16'h9000 gives 16'h8000.
- NL with `final_bank`=1, inputs summing to -64:
  - nl_type 1 gives 0.
  - nl_type 2 gives -8.
  - nl_type 3 with a sum of 16'h0700 gives 16'h0600.
  - nl_type 5 passes -64.
- Pool with `row_length`=4, rows [1,5,2,3] and [4,0,9,1]. Expect exactly two outputs, 5 then 9. Repeat with `row_length`=5 (extra pixel per row); the outputs are the same.
- `pool_clear` asserted mid odd row gives no output for the partial window. The next two rows pool correctly from column 0.
- Reset asserted during a full pipe: next cycle `out_valid`=0, `pipe_empty`=1, and no stale output afterwards. `row_length`=1 with `pool_en` sets `cfg_err` and gives zero outputs.

Source files
------------

// File: rtl/pe_pipe.sv
// pe_pipe: back-end datapath of a processing element.
// Reduces N_CH channel products through a registered adder tree, optionally
// adds a fed-back partial sum, saturates, applies a selectable non-linearity
// and an optional 2x2 max-pool that uses a half-row line buffer.
module pe_pipe #(
   parameter int          N_CH      = 16,
   parameter int          W         = 16,
   parameter int          MAX_ROW   = 256,
   parameter int          RA        = 8,
   parameter logic [W-1:0] CLAMP_MAX = 16'h0600
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [W*N_CH-1:0]   in_data,
   input  logic [W-1:0]        psum_in,
   input  logic                acc_en,
   input  logic                final_bank,
   input  logic [2:0]          nl_type,
   input  logic                pool_en,
   input  logic [RA-1:0]       row_length,
   input  logic                pool_clear,
   output logic                out_valid,
   output logic [W-1:0]        out_data,
   output logic                pipe_empty,
   output logic                cfg_err
);

   localparam int T   = (N_CH > 1) ? $clog2(N_CH) : 0;
   localparam int NP  = 1 << T;
   localparam int SW  = W + T;
   localparam int LBD = MAX_ROW / 2;
   localparam int LA  = (LBD > 1) ? $clog2(LBD) : 1;

   typedef enum logic [1:0] {
      EVEN_A = 2'd0,
      EVEN_B = 2'd1,
      ODD_A  = 2'd2,
      ODD_B  = 2'd3
   } poolState_t;

   // Outputs of the reduction tree, aligned with their delayed side-band.
   logic signed [SW-1:0] tree_sum;
   logic                 tree_vld;
   logic                 tree_ae;
   logic signed [W-1:0]  tree_ps;
   logic                 tree_busy_d;

   if (T > 0) begin : g_tree
      logic signed [SW-1:0] leaf   [NP];
      logic signed [SW-1:0] node_q [1:NP-1];
      logic [T-1:0]         vld_q;
      logic [T-1:0]         vld_d;
      logic [T-1:0]         ae_q;
      logic signed [W-1:0]  ps_q   [T];

      // Sign-extend every channel to the full tree width; missing leaves are zero.
      always_comb begin
         for (int i = 0; i < N_CH; i++) begin
            leaf[i] = SW'(signed'(in_data[i*W +: W]));
         end
         for (int i = N_CH; i < NP; i++) begin
            leaf[i] = '0;
         end
      end

      // Valid bit shifts one tree level per cycle.
      always_comb begin
         vld_d[0] = in_valid;
         for (int k = 1; k < T; k++) begin
            vld_d[k] = vld_q[k-1];
         end
      end

      // Tree valid bits are the only state here that needs a reset.
      always_ff @(posedge clk) begin
         if (!rst) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
      end

      // Heap-ordered adder tree: node j sums children 2j and 2j+1; the
      // accumulate controls travel alongside in a matching delay line.
      always_ff @(posedge clk) begin
         for (int j = 1; j < NP; j++) begin
            if (2*j >= NP) begin
               node_q[j] <= leaf[2*j-NP] + leaf[2*j-NP+1];
            end else begin
               node_q[j] <= node_q[2*j] + node_q[2*j+1];
            end
         end
         ae_q[0] <= acc_en;
         ps_q[0] <= signed'(psum_in);
         for (int k = 1; k < T; k++) begin
            ae_q[k] <= ae_q[k-1];
            ps_q[k] <= ps_q[k-1];
         end
      end

      assign tree_sum    = node_q[1];
      assign tree_vld    = vld_q[T-1];
      assign tree_ae     = ae_q[T-1];
      assign tree_ps     = ps_q[T-1];
      assign tree_busy_d = |vld_d;
   end else begin : g_pass
      assign tree_sum    = SW'(signed'(in_data));
      assign tree_vld    = in_valid;
      assign tree_ae     = acc_en;
      assign tree_ps     = signed'(psum_in);
      assign tree_busy_d = 1'b0;
   end

   // Pipeline registers after the tree.
   logic signed [W-1:0] accData_q, accData_d;
   logic                accVld_q;
   logic signed [W-1:0] nlData_q, nlData_d;
   logic                nlVld_q;
   poolState_t          state_q, state_d;
   logic [RA-1:0]       col_q, col_d;
   logic signed [W-1:0] hold_q, hold_d;
   logic                outValid_q, outValid_d;
   logic signed [W-1:0] outData_q, outData_d;
   logic                cfgErr_q, cfgErr_d;
   logic                pipeEmpty_q, pipeEmpty_d;

   logic signed [W-1:0] lb [LBD];
   logic                lbWe;
   logic [LA-1:0]       lbIdx;
   logic signed [W-1:0] lbWdata;
   logic signed [SW:0]  accSum;

   function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Accumulate the fed-back partial sum and saturate to the output width.
   always_comb begin
      accSum = (SW+1)'(tree_sum) + (tree_ae ? (SW+1)'(tree_ps) : '0);
      if (accSum > $signed({{(SW-W+2){1'b0}}, {(W-1){1'b1}}})) begin
         accData_d = {1'b0, {(W-1){1'b1}}};
      end else if (accSum < $signed({{(SW-W+2){1'b1}}, {(W-1){1'b0}}})) begin
         accData_d = {1'b1, {(W-1){1'b0}}};
      end else begin
         accData_d = accSum[W-1:0];
      end
   end

   // Non-linearity, only for the final filter bank.
   always_comb begin
      nlData_d = accData_q;
      if (final_bank) begin
         case (nl_type)
            3'd1: nlData_d = (accData_q < 0) ? '0 : accData_q;
            3'd2: nlData_d = (accData_q < 0) ? (accData_q >>> 3) : accData_q;
            3'd3: begin
               if (accData_q < 0) begin
                  nlData_d = '0;
               end else if (accData_q > $signed(CLAMP_MAX)) begin
                  nlData_d = $signed(CLAMP_MAX);
               end else begin
                  nlData_d = accData_q;
               end
            end
            default: nlData_d = accData_q;
         endcase
      end
   end

   // Pool FSM and output stage: next state, line-buffer write and result.
   always_comb begin
      logic       poolOn;
      logic       cfgBad;
      logic       lastCol;
      poolState_t stEff;
      logic [RA-1:0] colEff;

      poolOn  = pool_en & final_bank;
      cfgBad  = poolOn && (row_length < RA'(2));
      stEff   = pool_clear ? EVEN_A : state_q;
      colEff  = pool_clear ? '0 : col_q;
      lastCol = (colEff >= row_length - RA'(1));

      state_d     = stEff;
      col_d       = colEff;
      hold_d      = hold_q;
      lbWe        = 1'b0;
      lbIdx       = colEff[LA:1];
      lbWdata     = smax(hold_q, nlData_q);
      outValid_d  = 1'b0;
      outData_d   = outData_q;
      cfgErr_d    = pool_clear ? 1'b0 : cfgErr_q;
      pipeEmpty_d = !(tree_busy_d | tree_vld | accVld_q);

      if (cfgBad) begin
         cfgErr_d = 1'b1;
      end

      if (nlVld_q) begin
         if (!poolOn) begin
            outValid_d = 1'b1;
            outData_d  = nlData_q;
         end else if (!cfgBad) begin
            case (stEff)
               EVEN_A, ODD_A: hold_d = nlData_q;
               EVEN_B:        lbWe   = 1'b1;
               ODD_B: begin
                  outValid_d = 1'b1;
                  outData_d  = smax(lb[lbIdx], smax(hold_q, nlData_q));
               end
               default: hold_d = hold_q;
            endcase
            if (lastCol) begin
               col_d   = '0;
               state_d = (stEff == EVEN_A || stEff == EVEN_B) ? ODD_A : EVEN_A;
            end else begin
               col_d = colEff + RA'(1);
               case (stEff)
                  EVEN_A:  state_d = EVEN_B;
                  EVEN_B:  state_d = EVEN_A;
                  ODD_A:   state_d = ODD_B;
                  default: state_d = ODD_A;
               endcase
            end
         end
      end
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         accVld_q    <= 1'b0;
         nlVld_q     <= 1'b0;
         state_q     <= EVEN_A;
         col_q       <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         cfgErr_q    <= 1'b0;
         pipeEmpty_q <= 1'b1;
      end else begin
         accVld_q    <= tree_vld;
         nlVld_q     <= accVld_q;
         state_q     <= state_d;
         col_q       <= col_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         cfgErr_q    <= cfgErr_d;
         pipeEmpty_q <= pipeEmpty_d;
      end
   end

   // Data registers carry no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      accData_q <= accData_d;
      nlData_q  <= nlData_d;
      hold_q    <= hold_d;
   end

   // Half-row line buffer holding the even-row horizontal maxima.
   always_ff @(posedge clk) begin
      if (lbWe) begin
         lb[lbIdx] <= lbWdata;
      end
   end

   assign out_valid  = outValid_q;
   assign out_data   = outData_q;
   assign pipe_empty = pipeEmpty_q;
   assign cfg_err    = cfgErr_q;

endmodule

// File: tb/tb_pe_pipe.sv
// tb_pe_pipe: scoreboard bench for pe_pipe with N_CH=4 (latency 5).
module tb_pe_pipe;

   localparam int NCH = 4;
   localparam int W   = 16;
   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic [15:0] psum_in = '0;
   logic        acc_en = 1'b0;
   logic        final_bank = 1'b0;
   logic [2:0]  nl_type = '0;
   logic        pool_en = 1'b0;
   logic [7:0]  row_length = 8'd4;
   logic        pool_clear = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;
   logic        pipe_empty;
   logic        cfg_err;

   pe_pipe #(.N_CH(NCH), .W(W), .MAX_ROW(256), .RA(8), .CLAMP_MAX(16'h0600)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .psum_in(psum_in), .acc_en(acc_en), .final_bank(final_bank),
      .nl_type(nl_type), .pool_en(pool_en), .row_length(row_length),
      .pool_clear(pool_clear), .out_valid(out_valid), .out_data(out_data),
      .pipe_empty(pipe_empty), .cfg_err(cfg_err)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int data;
      int due;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model state: full rows of pooled pixels.
   int mCol = 0;
   int mOdd = 0;
   int prevRow[256];
   int curRow[256];

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic int nlRef(input int x, input int t);
      case (t)
         1: return (x < 0) ? 0 : x;
         2: return (x < 0) ? (x >>> 3) : x;
         3: return (x < 0) ? 0 : ((x > 1536) ? 1536 : x);
         default: return x;
      endcase
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic pushExpected(input int data, input int due);
      exp_t e;
      e.data = data;
      e.due  = due;
      expQ.push_back(e);
   endtask

   task automatic modelPool(input int x, input int due);
      int rl;
      rl = int'(row_length);
      if (rl < 2) return;
      curRow[mCol] = x;
      if (mOdd == 1 && (mCol % 2) == 1) begin
         pushExpected(max2(max2(prevRow[mCol-1], prevRow[mCol]),
                           max2(curRow[mCol-1], curRow[mCol])), due);
      end
      if (mCol == rl - 1) begin
         if (mOdd == 0) begin
            for (int i = 0; i < rl; i++) prevRow[i] = curRow[i];
         end
         mOdd = 1 - mOdd;
         mCol = 0;
      end else begin
         mCol++;
      end
   endtask

   task automatic modelSample(input logic [63:0] d, input logic ae, input logic [15:0] ps);
      int s;
      s = 0;
      for (int i = 0; i < NCH; i++) s += $signed(d[16*i +: 16]);
      if (ae) s += $signed(ps);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (final_bank) s = nlRef(s, int'(nl_type));
      if (pool_en && final_bank) modelPool(s, cyc + LAT);
      else pushExpected(s, cyc + LAT);
   endtask

   // Drive one cycle of input and record its expected result.
   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ae, input logic [15:0] ps);
      @(posedge clk);
      #1;
      in_valid   = v;
      in_data    = d;
      acc_en     = ae;
      psum_in    = ps;
      pool_clear = 1'b0;
      if (v) modelSample(d, ae, ps);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b0, '0);
   endtask

   task automatic drainPipe();
      idle(10);
      checkOutput("drain_queue_empty", expQ.size(), 0);
      checkOutput("drain_pipe_empty", int'(pipe_empty), 1);
   endtask

   task automatic clearPool();
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      pool_clear = 1'b1;
      mCol = 0;
      mOdd = 0;
   endtask

   task automatic pixel(input int p);
      applyStimulus(1'b1, pack4(p, 0, 0, 0), 1'b0, '0);
   endtask

   task automatic setPool(input int rl);
      final_bank = 1'b1;
      nl_type    = 3'd0;
      pool_en    = 1'b1;
      row_length = rl[7:0];
      clearPool();
   endtask

   // Reset for one edge; results due after that edge are discarded.
   task automatic doReset();
      exp_t keep[$];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;
      foreach (expQ[i]) if (expQ[i].due <= cyc) keep.push_back(expQ[i]);
      expQ = keep;
      mCol = 0;
      mOdd = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_out_data", int'(out_data), 0);
      checkOutput("reset_pipe_empty", int'(pipe_empty), 1);
   endtask

   // Monitor: every presented result is matched against the scoreboard head.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_output: got %0d at cycle %0d, expected no output",
                     $signed(out_data), cyc);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            if (int'($signed(out_data)) != e.data || cyc != e.due) begin
               fails++;
               $display("[TB] FAIL scoreboard: got %0d at cycle %0d, expected %0d at cycle %0d",
                        $signed(out_data), cyc, e.data, e.due);
            end
         end
      end
   end

   initial begin
      int rowA[5];
      int rowB[5];
      rowA = '{1, 5, 2, 3, 7};
      rowB = '{4, 0, 9, 1, 8};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_out_data", int'(out_data), 0);
      checkOutput("reset_pipe_empty", int'(pipe_empty), 1);
      checkOutput("reset_cfg_err", int'(cfg_err), 0);
      rst = 1'b1;

      // Plain reduction, back-to-back.
      applyStimulus(1'b1, pack4(1, 2, 3, 4), 1'b0, '0);
      applyStimulus(1'b1, pack4(-5, 0, 0, 0), 1'b0, '0);
      checkOutput("busy_pipe_empty", int'(pipe_empty), 0);
      drainPipe();
      checkOutput("hold_last", int'($signed(out_data)), -5);

      // Saturation with and without accumulate.
      applyStimulus(1'b1, pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 1'b1, 16'h7000);
      applyStimulus(1'b1, pack4(-28672, -28672, -28672, -28672), 1'b0, '0);
      applyStimulus(1'b1, pack4(100, -20, 3, 0), 1'b1, 16'hFFF0);
      drainPipe();

      // Non-linearities on the final bank.
      final_bank = 1'b1;
      for (int t = 1; t <= 5; t += 1) begin
         if (t == 4) continue;
         nl_type = t[2:0];
         applyStimulus(1'b1, pack4(-16, -16, -16, -16), 1'b0, '0);
         applyStimulus(1'b1, pack4(16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0), 1'b0, '0);
         drainPipe();
      end

      // Pooling with even and odd row lengths.
      for (int rl = 4; rl <= 5; rl++) begin
         setPool(rl);
         for (int i = 0; i < rl; i++) pixel(rowA[i]);
         for (int i = 0; i < rl; i++) pixel(rowB[i]);
         drainPipe();
      end

      // pool_clear in the middle of an odd row.
      setPool(4);
      for (int i = 0; i < 4; i++) pixel(rowA[i]);
      for (int i = 0; i < 3; i++) pixel(rowB[i]);
      drainPipe();
      clearPool();
      for (int i = 0; i < 4; i++) pixel(rowB[i] + 10);
      for (int i = 0; i < 4; i++) pixel(rowA[i] - 3);
      drainPipe();

      // Reset mid-row while pooling, then fresh rows.
      setPool(4);
      for (int i = 0; i < 4; i++) pixel(rowA[i]);
      pixel(4);
      pixel(0);
      doReset();
      for (int i = 0; i < 4; i++) pixel(rowB[i]);
      for (int i = 0; i < 4; i++) pixel(rowA[i]);
      drainPipe();

      // Reset with a full non-pool pipe.
      final_bank = 1'b0;
      pool_en    = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, pack4(i, i, 1, 2), 1'b0, '0);
      doReset();
      drainPipe();

      // Degenerate row length.
      setPool(1);
      for (int i = 0; i < 6; i++) pixel(i + 1);
      drainPipe();
      checkOutput("cfg_err_set", int'(cfg_err), 1);
      row_length = 8'd4;
      clearPool();
      idle(1);
      checkOutput("cfg_err_cleared", int'(cfg_err), 0);
      drainPipe();

      // Randomised non-pool traffic per configuration.
      for (int c = 0; c < 6; c++) begin
         final_bank = 1'($urandom % 2);
         nl_type    = 3'($urandom % 8);
         pool_en    = 1'b0;
         for (int i = 0; i < 25; i++) begin
            logic [63:0] d;
            if ($urandom % 2 == 0) d = {$urandom, $urandom};
            else d = pack4($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200,
                           $urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200);
            applyStimulus(1'($urandom % 4 != 0), d, 1'($urandom % 2), 16'($urandom));
         end
         drainPipe();
      end

      // Randomised pooling.
      for (int c = 0; c < 4; c++) begin
         setPool($urandom_range(2, 9));
         nl_type = 3'($urandom % 8);
         for (int i = 0; i < 4 * int'(row_length); i++) begin
            if ($urandom % 3 == 0) idle(1);
            applyStimulus(1'b1, pack4($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300,
                                      $urandom_range(0, 600) - 300, 0),
                          1'($urandom % 2), 16'($urandom_range(0, 200)));
         end
         drainPipe();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
